// File: rtl/mant_mul_arb_pkg.sv
// Shared types for the mantissa-multiplier arbiter: operand/product widths, pipeline slots, Booth digit decode.
// Slot fields are sized for the largest supported configuration (8 lanes, 16-bit tags).
package mant_mul_arb_pkg;

  localparam int MANT_W    = 11;
  localparam int PROD_W    = 22;
  localparam int OWNER_W   = 3;
  localparam int TAG_MAX_W = 16;

  typedef logic [MANT_W-1:0] mant_t;
  typedef logic [PROD_W-1:0] prod_t;

  typedef struct packed {
    logic                 valid;
    logic [OWNER_W-1:0]   owner;
    logic [TAG_MAX_W-1:0] tag;
    prod_t                prod;
  } mul_slot_t;

  typedef struct packed {
    logic                 valid;
    logic [OWNER_W-1:0]   owner;
    logic [TAG_MAX_W-1:0] tag;
    mant_t                a;
    mant_t                b;
  } iss_slot_t;

  typedef enum logic [2:0] {
    BOOTH_ZERO,
    BOOTH_P1,
    BOOTH_P2,
    BOOTH_M1,
    BOOTH_M2
  } booth_sel_e;

  // Radix-4 digit from the overlapping bit triplet {b[2i+1], b[2i], b[2i-1]}.
  function automatic booth_sel_e booth_decode(input logic [2:0] trip);
    case (trip)
      3'b001, 3'b010: return BOOTH_P1;
      3'b011:         return BOOTH_P2;
      3'b100:         return BOOTH_M2;
      3'b101, 3'b110: return BOOTH_M1;
      default:        return BOOTH_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/mant_mul_rr_arb.sv
// Round-robin arbiter: one-hot grant searched upward from a pointer, combinational from req/en.
// Pointer moves past the winner only on a grant; i_en low blocks all grants.
module mant_mul_rr_arb #(
  parameter int N = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N-1:0]         i_req,
  input  logic                 i_en,
  output logic [N-1:0]         o_gnt,
  output logic [$clog2(N)-1:0] o_gnt_idx
);

  localparam int PTR_W = $clog2(N);

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_idx;
  logic             w_found;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    w_sum     = '0;
    w_idx     = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(N)) begin
        w_sum = w_sum - (PTR_W+1)'(N);
      end
      w_idx = w_sum[PTR_W-1:0];
      if (!w_found && i_req[w_idx]) begin
        w_found   = 1'b1;
        o_gnt_idx = w_idx;
      end
    end
    if (w_found && i_en) begin
      o_gnt[o_gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (|o_gnt) begin
      r_ptr <= (o_gnt_idx == PTR_W'(N-1)) ? '0 : o_gnt_idx + PTR_W'(1);
    end
  end

endmodule

// File: rtl/mbe_mantissa_mul.sv
// Unsigned 11x11 -> 22-bit radix-4 Booth multiplier; purely combinational, no handshake.
// Partial products are formed mod 2^22, which is exact since the true product always fits.
module mbe_mantissa_mul
  import mant_mul_arb_pkg::*;
(
  input  mant_t i_a,
  input  mant_t i_b,
  output prod_t o_prod
);

  localparam int NUM_PP = MANT_W / 2 + 1;

  // Zero below the LSB for digit 0, zero above the MSB so the top digit is never negative.
  logic [MANT_W+1:0] w_bx;
  prod_t             w_pp [NUM_PP];
  prod_t             w_acc;

  assign w_bx = {1'b0, i_b, 1'b0};

  for (genvar gi = 0; gi < NUM_PP; gi++) begin : g_pp
    booth_sel_e w_sel;
    prod_t      w_mag;
    logic       w_neg;

    assign w_sel = booth_decode(w_bx[2*gi+2 -: 3]);
    assign w_neg = (w_sel == BOOTH_M1) || (w_sel == BOOTH_M2);

    always_comb begin
      w_mag = '0;
      case (w_sel)
        BOOTH_P1, BOOTH_M1: w_mag = PROD_W'(i_a);
        BOOTH_P2, BOOTH_M2: w_mag = PROD_W'({i_a, 1'b0});
        default:            w_mag = '0;
      endcase
    end

    assign w_pp[gi] = (w_neg ? (~w_mag + PROD_W'(1)) : w_mag) << (2 * gi);
  end

  // Reduction tree is left to synthesis as a flat carry-save sum.
  always_comb begin
    w_acc = '0;
    for (int i = 0; i < NUM_PP; i++) begin
      w_acc = w_acc + w_pp[i];
    end
  end

  assign o_prod = w_acc;

endmodule

// File: rtl/mant_mul_arbiter.sv
// Shares one mantissa multiplier among NUM_REQ lanes; latency PIPE_STAGES+1, 1 product/cycle.
// Whole pipe freezes and grants stop while the owner holds off the result; MANT_MUL_ARB_PERF_CNT_EN adds counters.
module mant_mul_arbiter
  import mant_mul_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int PIPE_STAGES = 1,
  parameter int TAG_W       = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ-1:0][MANT_W-1:0] req_a_i,
  input  logic [NUM_REQ-1:0][MANT_W-1:0] req_b_i,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]  req_tag_i,
  output logic [NUM_REQ-1:0]             rsp_valid_o,
  input  logic [NUM_REQ-1:0]             rsp_ready_i,
  output logic [PROD_W-1:0]              rsp_prod_o,
  output logic [TAG_W-1:0]               rsp_tag_o,
  output logic [NUM_REQ-1:0][15:0]       grant_cnt_o,
  output logic [15:0]                    stall_cnt_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] w_gnt;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic               w_stall;
  logic               w_arb_en;
  prod_t              w_prod;
  mul_slot_t          w_out;
  iss_slot_t          r_iss;
  mul_slot_t          r_pp [PIPE_STAGES];

  assign w_out = r_pp[PIPE_STAGES-1];

  always_comb begin
    rsp_valid_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid_o[i] = w_out.valid && (w_out.owner == OWNER_W'(i));
    end
  end

  // rsp_valid_o is one-hot on the owner, so this ignores every other lane's ready.
  assign w_stall    = w_out.valid && !(|(rsp_valid_o & rsp_ready_i));
  assign w_arb_en   = !w_stall && !rst_i;
  assign rsp_prod_o = w_out.prod;
  assign rsp_tag_o  = TAG_W'(w_out.tag);

  mant_mul_rr_arb #(
    .N (NUM_REQ)
  ) u_arb (
    .i_clk     (clk_i),
    .i_rst     (rst_i),
    .i_req     (req_valid_i),
    .i_en      (w_arb_en),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  assign req_ready_o = w_gnt;

  mbe_mantissa_mul u_mul (
    .i_a    (r_iss.a),
    .i_b    (r_iss.b),
    .o_prod (w_prod)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_iss <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) begin
        r_pp[s] <= '0;
      end
    end else if (!w_stall) begin
      r_iss.valid <= |w_gnt;
      r_iss.owner <= OWNER_W'(w_gnt_idx);
      r_iss.tag   <= TAG_MAX_W'(req_tag_i[w_gnt_idx]);
      r_iss.a     <= req_a_i[w_gnt_idx];
      r_iss.b     <= req_b_i[w_gnt_idx];
      r_pp[0]     <= '{valid: r_iss.valid, owner: r_iss.owner, tag: r_iss.tag, prod: w_prod};
      for (int s = 1; s < PIPE_STAGES; s++) begin
        r_pp[s] <= r_pp[s-1];
      end
    end
  end

`ifdef MANT_MUL_ARB_PERF_CNT_EN
  logic [NUM_REQ-1:0][15:0] r_grant_cnt;
  logic [15:0]              r_stall_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_grant_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_gnt[i] && (r_grant_cnt[i] != 16'hFFFF)) begin
          r_grant_cnt[i] <= r_grant_cnt[i] + 16'd1;
        end
      end
      if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign grant_cnt_o = r_grant_cnt;
  assign stall_cnt_o = r_stall_cnt;
`else
  assign grant_cnt_o = '0;
  assign stall_cnt_o = '0;
`endif

endmodule

// File: doc/mant_mul_arbiter.md
# mant_mul_arbiter

Shares one 11x11 radix-4 Booth/Dadda mantissa multiplier (`mbe_mantissa_mul`) among `NUM_REQ` FPU lanes.

- Grants requesters round-robin and registers operands into an issue stage.
- Pipelines the 22-bit product and routes it, with its tag, back to the owning lane over a valid/ready handshake.
- Applies global backpressure when the owning lane stalls.
- Sits between the FMA/multiply lanes of the FPU and the single shared multiplier instance.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, range 2..8.
- `PIPE_STAGES`, 1: product register stages after the multiplier, range 1..3.
- `TAG_W`, 4: width of the opaque request tag.

Ports:
- `clk_i`, in, 1: clock. One clock domain.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `req_valid_i`, in, `NUM_REQ`: per-lane request valid.
- `req_ready_o`, out, `NUM_REQ`: one-hot grant. At most one bit is high per cycle.
- `req_a_i`, in, `NUM_REQ`x11: mantissa operand A per lane, hidden bit included.
- `req_b_i`, in, `NUM_REQ`x11: mantissa operand B per lane.
- `req_tag_i`, in, `NUM_REQ`x`TAG_W`: per-lane tag, returned unchanged with the result.
- `rsp_valid_o`, out, `NUM_REQ`: one-hot result valid for the owning lane.
- `rsp_ready_i`, in, `NUM_REQ`: per-lane result accept.
- `rsp_prod_o`, out, 22: product, unsigned A*B. Shared bus.
- `rsp_tag_o`, out, `TAG_W`: tag of the result. Shared bus.
- `grant_cnt_o`, out, `NUM_REQ`x16: grant counters (see Configuration).
- `stall_cnt_o`, out, 16: stall-cycle counter (see Configuration).

## Operation
- Pipeline: issue register → multiplier (combinational) → `PIPE_STAGES` product registers. The last register drives the `rsp_*` outputs.
- Each slot holds `{valid, owner, tag}`. The issue slot also holds `{a, b}`; product slots hold `prod`.
- Stall condition: `stall = out.valid & ~rsp_ready_i[out.owner]`. When `stall` is high, every pipeline register holds its value and no grant is issued.
- Bubbles are not compressed.
- Arbitration:
  - Round-robin pointer `ptr`, reset value 0.
  - Grant goes to the first `i` with `req_valid_i[i]`, searching from `ptr` upward and wrapping modulo `NUM_REQ`.
  - After a handshake by lane `g`, `ptr` becomes `(g+1) mod NUM_REQ`. With no handshake, `ptr` is unchanged.
- `req_ready_o` is combinational from `req_valid_i`, `ptr` and `stall`.
- A lane holds valid, operands and tag stable until it sees ready. Deasserting valid before grant is permitted.
- Results return in issue order. The tag and owner travel unchanged with the data.
- Arithmetic is an unsigned 11x11 → 22-bit product with no truncation. Example: `0x7FF*0x7FF = 0x3FF001`.
- Reset values:
  - `req_ready_o`, `rsp_valid_o`: all 0.
  - `rsp_prod_o`, `rsp_tag_o`: 0.
  - Every slot valid bit: 0.
  - `ptr`: 0.
  - Counters: 0.
- Reset mid-operation clears all slots. In-flight results are discarded and are never presented.
- The output-slot owner does not get priority: it still arbitrates for new requests while its result waits.

## Timing
- Latency is `PIPE_STAGES+1` cycles. A handshake in cycle t produces `rsp_valid_o` in cycle t+`PIPE_STAGES`+1, assuming no stalls.
- Throughput is one product per cycle while no stall occurs.
- A result is consumed in a cycle where `rsp_valid_o[k]` and `rsp_ready_i[k]` are both high. In that same cycle the pipeline advances and a new grant is possible, so there is no bubble penalty.
- Simultaneous events:
  - Stall and new requests in the same cycle: no grant that cycle.
  - Reset and any handshake in the same cycle: reset wins and the handshake is void.
- `rsp_ready_i` of non-owner lanes is ignored.

## Configuration
- Macro: `MANT_MUL_ARB_PERF_CNT_EN`.
- Defined:
  - `grant_cnt_o[i]` increments on each handshake of lane i.
  - `stall_cnt_o` increments on each cycle with `stall` high.
  - All counters are 16-bit and saturate at `0xFFFF`. Reset clears them.
- Not defined: the counter logic is absent and both counter ports are tied to 0.

## Structure
- Shared package `mant_mul_arb_pkg` contains:
  - `MANT_W=11`, `PROD_W=22`.
  - Typedefs `mant_t` and `prod_t`.
  - Slot struct `mul_slot_t` with fields valid, owner index, tag, prod.
- Sub-module `mant_mul_rr_arb`: parameterised round-robin arbiter.
  - Inputs: `req`, `en` (`~stall`).
  - Outputs: one-hot `gnt`; pointer update.
- Top level instantiates `mant_mul_rr_arb`, the issue register, `mbe_mantissa_mul`, and the product pipeline.

## Test plan
- Single request, lane 0, `A=0x400`, `B=0x400`, tag 5 → `req_ready_o=0001` in the same cycle. Two cycles later (`PIPE_STAGES=1`): `rsp_valid_o=0001`, `rsp_prod_o=0x100000`, `rsp_tag_o=5`.
- All four lanes hold valid from reset → grants go to lanes 0,1,2,3,0,… in consecutive cycles. Responses appear in the same order at 1 per cycle, with products matching a golden model.
- Lane 2 result present with `rsp_ready_i[2]=0` for 3 cycles while lanes 0 and 1 request → no grants and outputs frozen for 3 cycles. Pipeline resumes on the accept cycle. `stall_cnt_o=3` with the macro defined.
- Edge operands → product and tag correct:
  - `0x7FF*0x7FF=0x3FF001`
  - `0x000*0x7FF=0`
  - `0x001*0x001=1`
- Assert `rst_i` while 2 results are in flight → no `rsp_valid_o` pulse afterwards, `ptr` back to 0, and the next lane-3 request is granted immediately.
- Hold 70000 grants on lane 1 with the macro defined → `grant_cnt_o[1]` saturates at `0xFFFF`. With the macro undefined, both counter ports stay 0 throughout.
